// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dmem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_WAIT,
    RESP
  } arb_state_t;

  // Requester indices (also bit positions in the grant vector)
  localparam int REQ_PIPE = 0;
  localparam int REQ_DBG  = 1;

  // Width of the read-latency down-counter (MEM_LATENCY up to 15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin arbiter. Purely combinational; the last-grant
// register is kept by the parent so it only moves on an accepted grant.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  // Each requester wins when it is alone, or on a tie when it was not the last winner
  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt[gi] = en & req[gi] & (~req[1-gi] | (last_gnt != 1'(gi)));
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and the
// debug/DMA port. Stores take one memory cycle, loads hold read_enable for
// MEM_LATENCY cycles and return the raw word on a one-cycle rvalid pulse.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_req,
  input  logic            p_we,
  input  logic [XLEN-1:0] p_addr,
  input  logic [XLEN-1:0] p_wdata,
  output logic            p_gnt,
  output logic            p_rvalid,
  output logic [XLEN-1:0] p_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            dm_read_enable,
  output logic            dm_write_enable,
  output logic [XLEN-1:0] dm_read_addr,
  output logic [XLEN-1:0] dm_write_addr,
  output logic [XLEN-1:0] dm_write_data,
  input  logic [XLEN-1:0] dm_read_data,
  output logic            busy
);

  arb_state_t       state_reg, state_next;
  logic             last_gnt_reg;
  logic             owner_reg;
  logic             we_reg;
  logic [XLEN-1:0]  addr_reg;
  logic [XLEN-1:0]  wdata_reg;
  logic [XLEN-1:0]  rdata_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [1:0]       gnt;
  logic             arb_en;
  logic             grant_any;
  logic             grant_dbg;

  // RESP doubles as an idle cycle so a new grant can overlap the response;
  // grants are suppressed while reset is held so every output reads 0
  assign arb_en    = rst_n & ((state_reg == IDLE) | (state_reg == RESP));
  assign grant_any = |gnt;
  assign grant_dbg = gnt[REQ_DBG];

  dmem_rr_arbiter u_rr (
    .req      ({d_req, p_req}),
    .last_gnt (last_gnt_reg),
    .en       (arb_en),
    .gnt      (gnt)
  );

  assign p_gnt = gnt[REQ_PIPE];
  assign d_gnt = gnt[REQ_DBG];
  assign busy  = (state_reg != IDLE);

  // Next-state logic plus memory-side and response outputs, all 0 by default
  always_comb begin
    state_next      = state_reg;
    dm_read_enable  = 1'b0;
    dm_write_enable = 1'b0;
    dm_read_addr    = '0;
    dm_write_addr   = '0;
    dm_write_data   = '0;
    p_rvalid        = 1'b0;
    d_rvalid        = 1'b0;
    p_rdata         = '0;
    d_rdata         = '0;
    case (state_reg)
      IDLE, RESP: begin
        if (state_reg == RESP) begin
          if (owner_reg == 1'(REQ_DBG)) begin
            d_rvalid = 1'b1;
            d_rdata  = rdata_reg;
          end else begin
            p_rvalid = 1'b1;
            p_rdata  = rdata_reg;
          end
        end
        if (grant_any) begin
          state_next = (grant_dbg ? d_we : p_we) ? WR : RD_WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WR: begin
        dm_write_enable = 1'b1;
        dm_write_addr   = addr_reg;
        dm_write_data   = wdata_reg;
        state_next      = IDLE;
      end
      RD_WAIT: begin
        dm_read_enable = 1'b1;
        dm_read_addr   = addr_reg;
        if (cnt_reg == '0) begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, capture registers, latency counter and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_any) begin
        last_gnt_reg <= grant_dbg;
        owner_reg    <= grant_dbg;
        we_reg       <= grant_dbg ? d_we    : p_we;
        addr_reg     <= grant_dbg ? d_addr  : p_addr;
        wdata_reg    <= grant_dbg ? d_wdata : p_wdata;
        cnt_reg      <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_reg == RD_WAIT) begin
        if (cnt_reg == '0) begin
          rdata_reg <= dm_read_data;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

  // The captured direction is implied by the state; kept for debug visibility
  logic unused_we;
  assign unused_we = we_reg;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter: a per-cycle vector table for the
// basic load/store/overlap flows, plus hand-written multi-cycle sequences.
module tb_dmem_access_arbiter;

  localparam int XLEN = 32;

  typedef struct packed {
    logic        p_gnt;
    logic        p_rvalid;
    logic [31:0] p_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        re;
    logic        we;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        pr, pw;
    logic [31:0] pa, pd;
    logic        dr, dw;
    logic [31:0] da, dd;
    outs_t       e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- instance 0: MEM_LATENCY = 2 ----------------
  logic rst_n, p_req, p_we, d_req, d_we;
  logic [XLEN-1:0] p_addr, p_wdata, d_addr, d_wdata;
  logic p_gnt, p_rvalid, d_gnt, d_rvalid, dm_re, dm_we, busy;
  logic [XLEN-1:0] p_rdata, d_rdata, dm_raddr, dm_waddr, dm_wdata, dm_rdata;

  dmem_access_arbiter #(.XLEN(XLEN), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dm_read_enable(dm_re), .dm_write_enable(dm_we),
    .dm_read_addr(dm_raddr), .dm_write_addr(dm_waddr),
    .dm_write_data(dm_wdata), .dm_read_data(dm_rdata),
    .busy(busy)
  );

  // ---------------- instance 1: MEM_LATENCY = 1 ----------------
  logic rst1_n, q_req;
  logic [XLEN-1:0] q_addr;
  logic q_gnt, q_rvalid, e_gnt, e_rvalid, dm1_re, dm1_we, busy1;
  logic [XLEN-1:0] q_rdata, e_rdata, dm1_raddr, dm1_waddr, dm1_wdata, dm1_rdata;

  dmem_access_arbiter #(.XLEN(XLEN), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .p_req(q_req), .p_we(1'b0), .p_addr(q_addr), .p_wdata('0),
    .p_gnt(q_gnt), .p_rvalid(q_rvalid), .p_rdata(q_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_gnt(e_gnt), .d_rvalid(e_rvalid), .d_rdata(e_rdata),
    .dm_read_enable(dm1_re), .dm_write_enable(dm1_we),
    .dm_read_addr(dm1_raddr), .dm_write_addr(dm1_waddr),
    .dm_write_data(dm1_wdata), .dm_read_data(dm1_rdata),
    .busy(busy1)
  );

  // ---------------- memory models ----------------
  // Read data is only valid once read_enable has been held for the latency;
  // before that the model returns a poison word.
  logic        mem_load;
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [3:0]  en_cnt0, en_cnt1;
  logic        both_en_seen;

  // Memory write/preload and read-enable run-length tracking
  always @(posedge clk) begin
    if (mem_load) begin
      mem0[4]      <= 32'hDEADBEEF;
      mem1[16]     <= 32'h11111111;
      mem1[17]     <= 32'h22222222;
      en_cnt0      <= '0;
      en_cnt1      <= '0;
      both_en_seen <= 1'b0;
    end else begin
      if (dm_we)  mem0[dm_waddr[9:2]]  <= dm_wdata;
      if (dm1_we) mem1[dm1_waddr[9:2]] <= dm1_wdata;
      en_cnt0 <= dm_re  ? en_cnt0 + 4'd1 : 4'd0;
      en_cnt1 <= dm1_re ? en_cnt1 + 4'd1 : 4'd0;
      if ((dm_re && dm_we) || (dm1_re && dm1_we) || (p_gnt && d_gnt)) both_en_seen <= 1'b1;
    end
  end

  assign dm_rdata  = (dm_re  && en_cnt0 >= 4'd1) ? mem0[dm_raddr[9:2]]  : 32'hBAD0BAD0;
  assign dm1_rdata = (dm1_re && en_cnt1 >= 4'd0) ? mem1[dm1_raddr[9:2]] : 32'hBAD0BAD0;

  // ---------------- helpers ----------------
  function automatic outs_t o(logic pg, logic pv, logic [31:0] prd, logic dg, logic dv, logic [31:0] drd,
                              logic re, logic we, logic [31:0] ra, logic [31:0] wa, logic [31:0] wd, logic bz);
    return '{pg, pv, prd, dg, dv, drd, re, we, ra, wa, wd, bz};
  endfunction

  function automatic outs_t act0();
    return '{p_gnt, p_rvalid, p_rdata, d_gnt, d_rvalid, d_rdata, dm_re, dm_we, dm_raddr, dm_waddr, dm_wdata, busy};
  endfunction

  vec_t vecs[$];

  task automatic add(logic pr, logic pw, logic [31:0] pa, logic [31:0] pd,
                     logic dr, logic dw, logic [31:0] da, logic [31:0] dd, outs_t e);
    vec_t v;
    v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endtask

  task automatic drive_idle();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gcyc[$];
    int gid[$];
    int pv_cnt, dv_cnt;
    logic rsp_leak;

    drive_idle();
    q_req = 0; q_addr = '0;
    rst_n = 0; rst1_n = 0; mem_load = 1;

    // Per-cycle vectors: p group, d group, expected outputs
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,0,0,0,0,0,0));
    add(1,0,32'h10,0,          0,0,0,0,                          o(1,0,0,0,0,0,0,0,0,0,0,0));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,1,0,32'h10,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,1,0,32'h10,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,1,32'hDEADBEEF,0,0,0,0,0,0,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,0,0,0,0,0,0));
    add(0,0,0,0,               1,1,32'h20,32'h12345678,          o(0,0,0,1,0,0,0,0,0,0,0,0));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,0,1,0,32'h20,32'h12345678,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,0,0,0,0,0,0));
    add(0,0,0,0,               1,0,32'h20,0,                     o(0,0,0,1,0,0,0,0,0,0,0,0));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,1,0,32'h20,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,1,0,32'h20,0,0,1));
    add(1,0,32'h10,0,          0,0,0,0,                          o(1,0,0,0,1,32'h12345678,0,0,0,0,0,1));
    add(0,0,0,0,               1,1,32'h30,32'hAAAA5555,          o(0,0,0,0,0,0,1,0,32'h10,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,1,0,32'h10,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,1,32'hDEADBEEF,0,0,0,0,0,0,0,0,1));
    add(0,0,0,0,               0,0,0,0,                          o(0,0,0,0,0,0,0,0,0,0,0,0));

    repeat (2) @(negedge clk);
    mem_load = 0;
    #1 check("reset_outputs", 200'(act0()), 200'(outs_t'('0)));
    @(negedge clk);
    rst_n = 1; rst1_n = 1;

    foreach (vecs[i]) begin
      p_req = vecs[i].pr; p_we = vecs[i].pw; p_addr = vecs[i].pa; p_wdata = vecs[i].pd;
      d_req = vecs[i].dr; d_we = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dd;
      #1 check($sformatf("vec%0d", i), 200'(act0()), 200'(vecs[i].e));
      @(negedge clk);
    end
    drive_idle();

    // Both requesters held from reset release: alternate p,d,p,d every 3 cycles
    rst_n = 0;
    p_req = 1; p_addr = 32'h10; d_req = 1; d_addr = 32'h20;
    @(negedge clk);
    rst_n = 1;
    pv_cnt = 0; dv_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (p_gnt) begin gcyc.push_back(c); gid.push_back(0); end
      if (d_gnt) begin gcyc.push_back(c); gid.push_back(1); end
      if (p_rvalid) begin pv_cnt++; check($sformatf("tie_p_rdata_c%0d", c), 200'(p_rdata), 200'(32'hDEADBEEF)); end
      if (d_rvalid) begin dv_cnt++; check($sformatf("tie_d_rdata_c%0d", c), 200'(d_rdata), 200'(32'h12345678)); end
      @(negedge clk);
    end
    drive_idle();
    check("tie_grant_count", 200'(gcyc.size()), 200'(5));
    for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
      check($sformatf("tie_order_%0d", i), 200'(gid[i]), 200'(i % 2));
      check($sformatf("tie_cycle_%0d", i), 200'(gcyc[i]), 200'(3 * i));
    end
    check("tie_rvalid_counts", 200'({pv_cnt, dv_cnt}), 200'({32'd2, 32'd2}));
    repeat (4) @(negedge clk);

    // Reset during the first RD_WAIT cycle: read discarded, port then usable
    p_req = 1; p_addr = 32'h10;
    #1 check("rst_mid_gnt", 200'(p_gnt), 200'(1));
    @(negedge clk);
    p_req = 0;
    #1 check("rst_mid_rdwait", 200'({dm_re, dm_raddr}), 200'({1'b1, 32'h10}));
    rst_n = 0;
    #1 check("rst_mid_outputs", 200'(act0()), 200'(outs_t'('0)));
    @(negedge clk);
    rst_n = 1;
    rsp_leak = 0;
    for (int c = 0; c < 5; c++) begin
      #1 rsp_leak = rsp_leak | p_rvalid | d_rvalid | busy;
      @(negedge clk);
    end
    check("rst_mid_no_rvalid", 200'(rsp_leak), 200'(0));
    d_req = 1; d_we = 1; d_addr = 32'h50; d_wdata = 32'hCAFEF00D;
    #1 check("rst_after_gnt", 200'({p_gnt, d_gnt}), 200'(2'b01));
    @(negedge clk);
    drive_idle();
    #1 check("rst_after_write", 200'(act0()), 200'(o(0,0,0,0,0,0,0,1,0,32'h50,32'hCAFEF00D,1)));
    @(negedge clk);

    // Back-to-back loads with MEM_LATENCY=1: second grant lands on first rvalid
    q_req = 1; q_addr = 32'h40;
    #1 check("b2b_gnt1", 200'({q_gnt, q_rvalid}), 200'(2'b10));
    @(negedge clk);
    q_addr = 32'h44;
    #1 check("b2b_rd1", 200'({q_gnt, q_rvalid, dm1_re, dm1_raddr}), 200'({3'b001, 32'h40}));
    @(negedge clk);
    #1 check("b2b_rsp1_gnt2", 200'({q_gnt, q_rvalid, q_rdata}), 200'({2'b11, 32'h11111111}));
    @(negedge clk);
    q_req = 0;
    #1 check("b2b_rd2", 200'({q_gnt, q_rvalid, dm1_re, dm1_raddr}), 200'({3'b001, 32'h44}));
    @(negedge clk);
    #1 check("b2b_rsp2", 200'({q_gnt, q_rvalid, q_rdata, e_rvalid}), 200'({2'b01, 32'h22222222, 1'b0}));
    @(negedge clk);
    #1 check("b2b_idle", 200'({busy1, e_gnt, e_rdata}), 200'(0));

    check("no_enable_or_grant_overlap", 200'(both_en_seen), 200'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
